// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer (PC enable, imem req/gnt/rvalid, at most one fetch outstanding).
// Latency: combinational (Mealy) outputs; 2 cycles/instruction with gnt in REQ and rvalid next cycle.
// Backpressure: i_stall_IF parks a returned instruction in HOLD; PC is held until ID accepts it.
//
// Ports:
//   clk, i_rst_IF (async, active-high)
//   i_pc_src_EX, i_stall_IF, i_imem_gnt_IF, i_imem_rvalid_IF
//   o_imem_req_IF, o_en_IF, o_valid_ID, o_flush_ID, o_fetch_err_IF, o_stall_cnt
// Optional feature macro: FETCH_STALL_CNT_EN (stall-cycle counter on o_stall_cnt; else tied to 0).
module fetch_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             i_rst_IF,
  input  logic             i_pc_src_EX,
  input  logic             i_stall_IF,
  input  logic             i_imem_gnt_IF,
  input  logic             i_imem_rvalid_IF,
  output logic             o_imem_req_IF,
  output logic             o_en_IF,
  output logic             o_valid_ID,
  output logic             o_flush_ID,
  output logic             o_fetch_err_IF,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          err;
  logic          waiting;

  always_ff @(posedge clk or posedge i_rst_IF) begin
    if (i_rst_IF) begin
      state <= BOOT;
      tcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      if (tcnt_nxt == TMAX) err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    o_imem_req_IF = 1'b0;
    o_en_IF       = 1'b0;
    o_valid_ID    = 1'b0;
    o_flush_ID    = 1'b0;
    case (state)
      BOOT: state_nxt = REQ;
      default: begin
        if (i_pc_src_EX) begin
          // Redirect wins: PC reloads, IF/ID is killed. An outstanding fetch
          // still owes us a response, so WAIT/DRAIN must drain it first.
          o_en_IF    = 1'b1;
          o_flush_ID = 1'b1;
          case (state)
            WAIT, DRAIN: state_nxt = i_imem_rvalid_IF ? REQ : DRAIN;
            default:     state_nxt = REQ;
          endcase
        end else begin
          case (state)
            REQ: begin
              o_imem_req_IF = 1'b1;
              if (i_imem_gnt_IF) state_nxt = WAIT;
            end
            WAIT: begin
              if (i_imem_rvalid_IF) begin
                if (i_stall_IF) begin
                  state_nxt = HOLD;
                end else begin
                  o_valid_ID = 1'b1;
                  o_en_IF    = 1'b1;
                  state_nxt  = REQ;
                end
              end
            end
            HOLD: begin
              if (!i_stall_IF) begin
                o_valid_ID = 1'b1;
                o_en_IF    = 1'b1;
                state_nxt  = REQ;
              end
            end
            DRAIN: begin
              if (i_imem_rvalid_IF) state_nxt = REQ;
            end
            default: state_nxt = BOOT;
          endcase
        end
      end
    endcase
  end

  // Timeout counts idle cycles spent waiting on imem; any state change restarts it.
  always_comb begin
    waiting = ((state == WAIT) || (state == DRAIN)) && !i_imem_rvalid_IF;
    if (state_nxt != state)
      tcnt_nxt = '0;
    else if (waiting && (tcnt != TMAX))
      tcnt_nxt = tcnt + 1'b1;
    else
      tcnt_nxt = tcnt;
  end

  assign o_fetch_err_IF = err;

`ifdef FETCH_STALL_CNT_EN
  logic [CNT_W-1:0] scnt;

  always_ff @(posedge clk or posedge i_rst_IF) begin
    if (i_rst_IF)
      scnt <= '0;
    else if ((state != BOOT) && !o_en_IF && (scnt != '1))
      scnt <= scnt + 1'b1;
  end

  assign o_stall_cnt = scnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
